tdm_demux8: RTL and testbench

Time-division demultiplexer, the receive end of the team's 8:1 mux path. An 8-slot serial frame arrives on one line (`din`) with a slot-0 marker (`sync`), and the block distributes the bits onto 8 parallel outputs. A frame-sync state machine locks to the marker, tolerates a configurable number of missing markers, and resynchronises on a misplaced one. Completed frames are presented on a registered 8-bit bus with a one-cycle valid strobe.

---
 rtl/tdm_demux8.sv | 166 ++++++++++++++++
 tb/tb_tdm_demux8.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux8.sv
// 8:1 TDM receive demultiplexer with frame-sync lock, miss tolerance and resync.
// Optional even-parity slot enabled by defining TDM_DEMUX_PARITY_EN.
module tdm_demux8 #(
  parameter int unsigned SYNC_MISS_MAX = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       din,
  input  logic       sync,
  output logic [7:0] out,
  output logic       frame_valid,
  output logic [3:0] slot,
  output logic       locked,
  output logic       err,
  output logic       perr
);

`ifdef TDM_DEMUX_PARITY_EN
  localparam int unsigned SHW       = 8;
  localparam logic [3:0]  LAST_SLOT = 4'd8;
`else
  localparam int unsigned SHW       = 7;
  localparam logic [3:0]  LAST_SLOT = 4'd7;
`endif
  localparam logic [3:0] MISS_LIM = 4'(SYNC_MISS_MAX);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [3:0]     r_cnt, w_cnt_nxt;
  logic [2:0]     r_miss, w_miss_nxt;
  logic [SHW-1:0] r_shadow, w_shadow_nxt;
  logic [7:0]     r_out, w_out_nxt;
  logic [3:0]     r_slot, w_slot_nxt;
  logic           r_fv, w_fv_nxt;
  logic           r_err, w_err_nxt;
  logic           r_locked;
  logic [3:0]     w_miss_inc;

  assign w_miss_inc = {1'b0, r_miss} + 4'd1;

`ifdef TDM_DEMUX_PARITY_EN
  logic r_perr, w_perr_nxt;
  logic w_parity;
  assign w_parity = ^{r_shadow, din};
`endif

  // Next-state and next-output logic; pulses default low so they last one cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_miss_nxt   = r_miss;
    w_shadow_nxt = r_shadow;
    w_out_nxt    = r_out;
    w_fv_nxt     = 1'b0;
    w_err_nxt    = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    w_perr_nxt   = 1'b0;
`endif
    if (en) begin
      case (r_state)
        HUNT: begin
          if (sync) begin
            w_shadow_nxt[0] = din;
            w_cnt_nxt       = 4'd1;
            w_miss_nxt      = 3'd0;
            w_state_nxt     = RUN;
          end
        end
        RUN: begin
          if (sync && (r_cnt != 4'd0)) begin
            // Misplaced marker: drop the partial frame and restart at slot 1.
            w_err_nxt       = 1'b1;
            w_shadow_nxt    = '0;
            w_shadow_nxt[0] = din;
            w_cnt_nxt       = 4'd1;
          end else if (r_cnt == 4'd0) begin
            if (sync) begin
              w_miss_nxt      = 3'd0;
              w_shadow_nxt[0] = din;
              w_cnt_nxt       = 4'd1;
            end else if (w_miss_inc == MISS_LIM) begin
              w_err_nxt   = 1'b1;
              w_state_nxt = HUNT;
              w_miss_nxt  = 3'd0;
            end else begin
              w_miss_nxt      = w_miss_inc[2:0];
              w_shadow_nxt[0] = din;
              w_cnt_nxt       = 4'd1;
            end
          end else if (r_cnt == LAST_SLOT) begin
            w_cnt_nxt = 4'd0;
`ifdef TDM_DEMUX_PARITY_EN
            if (w_parity) begin
              w_perr_nxt = 1'b1;
            end else begin
              w_out_nxt = r_shadow;
              w_fv_nxt  = 1'b1;
            end
`else
            w_out_nxt = {din, r_shadow};
            w_fv_nxt  = 1'b1;
`endif
          end else begin
            w_shadow_nxt[r_cnt[2:0]] = din;
            w_cnt_nxt                = 4'(r_cnt + 4'd1);
          end
        end
        default: begin
          w_state_nxt = HUNT;
        end
      endcase
    end
`ifdef TDM_DEMUX_PARITY_EN
    w_slot_nxt = (w_state_nxt == RUN) ? w_cnt_nxt : 4'd0;
`else
    w_slot_nxt = (w_state_nxt == RUN) ? {1'b0, w_cnt_nxt[2:0]} : 4'd0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= HUNT;
      r_cnt    <= 4'd0;
      r_miss   <= 3'd0;
      r_shadow <= '0;
      r_out    <= 8'd0;
      r_slot   <= 4'd0;
      r_fv     <= 1'b0;
      r_err    <= 1'b0;
      r_locked <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      r_perr   <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_miss   <= w_miss_nxt;
      r_shadow <= w_shadow_nxt;
      r_out    <= w_out_nxt;
      r_slot   <= w_slot_nxt;
      r_fv     <= w_fv_nxt;
      r_err    <= w_err_nxt;
      r_locked <= (w_state_nxt == RUN);
`ifdef TDM_DEMUX_PARITY_EN
      r_perr   <= w_perr_nxt;
`endif
    end
  end

  assign out         = r_out;
  assign frame_valid = r_fv;
  assign slot        = r_slot;
  assign locked      = r_locked;
  assign err         = r_err;
`ifdef TDM_DEMUX_PARITY_EN
  assign perr        = r_perr;
`else
  assign perr        = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux8.sv
// Randomized + directed bench for tdm_demux8 against a queue-based frame model.
module tb_tdm_demux8;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int FLEN = 9;
`else
  localparam int FLEN = 8;
`endif
  localparam int MISS_MAX = 2;
  localparam int LAST = FLEN - 1;

  logic       clk, rst, en, din, sync;
  logic [7:0] out;
  logic       frame_valid, locked, err, perr;
  logic [3:0] slot;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: lock flag, bits received of the current frame, miss count
  bit         m_lock;
  int         m_miss;
  bit         m_q[$];
  logic [7:0] m_out;
  bit         m_fv, m_err, m_perr;

  tdm_demux8 #(.SYNC_MISS_MAX(MISS_MAX)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .din         (din),
    .sync        (sync),
    .out         (out),
    .frame_valid (frame_valid),
    .slot        (slot),
    .locked      (locked),
    .err         (err),
    .perr        (perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lock = 1'b0;
    m_miss = 0;
    m_q.delete();
    m_out  = 8'h00;
    m_fv   = 1'b0;
    m_err  = 1'b0;
    m_perr = 1'b0;
  endtask

  function automatic int m_slot();
    return m_lock ? m_q.size() : 0;
  endfunction

  task automatic model_step(input bit e, input bit s, input bit d);
    logic [7:0] v;
    int ones;
    m_fv = 1'b0; m_err = 1'b0; m_perr = 1'b0;
    if (!e) return;
    if (!m_lock) begin
      if (s) begin
        m_lock = 1'b1; m_miss = 0;
        m_q.delete(); m_q.push_back(d);
      end
      return;
    end
    if (s && m_q.size() != 0) begin
      m_err = 1'b1;
      m_q.delete(); m_q.push_back(d);
      return;
    end
    if (m_q.size() == 0) begin
      if (s) begin
        m_miss = 0;
        m_q.push_back(d);
      end else begin
        m_miss++;
        if (m_miss == MISS_MAX) begin
          m_err = 1'b1; m_lock = 1'b0; m_miss = 0;
        end else begin
          m_q.push_back(d);
        end
      end
      return;
    end
    m_q.push_back(d);
    if (m_q.size() == FLEN) begin
      v = 8'h00;
      ones = 0;
      for (int i = 0; i < 8; i++) v[i] = m_q[i];
      for (int i = 0; i < FLEN; i++) ones += int'(m_q[i]);
      if (FLEN == 8 || (ones % 2) == 0) begin
        m_out = v; m_fv = 1'b1;
      end else begin
        m_perr = 1'b1;
      end
      m_q.delete();
    end
  endtask

  task automatic compare_all();
    chk("out", out, m_out);
    chk("frame_valid", 8'(frame_valid), 8'(m_fv));
    chk("err", 8'(err), 8'(m_err));
    chk("perr", 8'(perr), 8'(m_perr));
    chk("slot", 8'(slot), 8'(m_slot()));
    chk("locked", 8'(locked), 8'(m_lock));
    chk("err_fv_excl", 8'(err & frame_valid), 8'h00);
  endtask

  task automatic step(input bit e, input bit s, input bit d);
    en = e; sync = s; din = d;
    @(posedge clk); #1;
    model_step(e, s, d);
    compare_all();
  endtask

  function automatic logic [8:0] fbits(input logic [7:0] b, input bit bad);
    return {(^b) ^ bad, b};
  endfunction

  task automatic send_bits(input logic [8:0] bits, input int lo, input int hi, input bit s0);
    for (int k = lo; k <= hi; k++) step(1'b1, s0 && (k == 0), bits[k]);
  endtask

  initial begin
    int gpos;
    bit e, s, d;
    rst = 1'b1; en = 1'b0; sync = 1'b0; din = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    chk("rst_out", out, 8'h00);
    rst = 1'b0;

    // Basic frame 0x4D
    send_bits(fbits(8'h4D, 1'b0), 0, LAST, 1'b1);
    chk("t1_out", out, 8'h4D);
    chk("t1_fv", 8'(frame_valid), 8'h01);
    chk("t1_locked", 8'(locked), 8'h01);

    // Back-to-back frames
    send_bits(fbits(8'hA5, 1'b0), 0, LAST, 1'b1);
    chk("t2_out_a5", out, 8'hA5);
    send_bits(fbits(8'h3C, 1'b0), 0, LAST, 1'b1);
    chk("t2_out_3c", out, 8'h3C);

    // Mid-frame stall at slot 3
    send_bits(fbits(8'hF0, 1'b0), 0, 2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'($urandom), 1'($urandom));
      chk("t3_slot_hold", 8'(slot), 8'h03);
    end
    send_bits(fbits(8'hF0, 1'b0), 3, LAST, 1'b0);
    chk("t3_out", out, 8'hF0);
    chk("t3_fv", 8'(frame_valid), 8'h01);

    // Misplaced sync at cnt=4
    send_bits(fbits(8'h5A, 1'b0), 0, 3, 1'b1);
    chk("t4_slot4", 8'(slot), 8'h04);
    send_bits(fbits(8'h96, 1'b0), 0, 0, 1'b1);
    chk("t4_err", 8'(err), 8'h01);
    chk("t4_slot1", 8'(slot), 8'h01);
    send_bits(fbits(8'h96, 1'b0), 1, LAST, 1'b0);
    chk("t4_out", out, 8'h96);

    // Missing syncs: first freewheels, second drops lock
    send_bits(fbits(8'h11, 1'b0), 0, LAST, 1'b1);
    send_bits(fbits(8'h22, 1'b0), 0, LAST, 1'b0);
    chk("t5_out_freewheel", out, 8'h22);
    chk("t5_fv_freewheel", 8'(frame_valid), 8'h01);
    step(1'b1, 1'b0, 1'b1);
    chk("t5_err", 8'(err), 8'h01);
    chk("t5_unlocked", 8'(locked), 8'h00);
    chk("t5_out_hold", out, 8'h22);

    // Asynchronous reset mid-frame
    send_bits(fbits(8'h33, 1'b0), 0, 3, 1'b1);
    rst = 1'b1;
    #2;
    model_reset();
    compare_all();
    chk("t6_out_zero", out, 8'h00);
    chk("t6_locked_zero", 8'(locked), 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b1);
    chk("t6_needs_sync", 8'(locked), 8'h00);

`ifdef TDM_DEMUX_PARITY_EN
    send_bits(fbits(8'h07, 1'b0), 0, LAST, 1'b1);
    chk("t7_fv", 8'(frame_valid), 8'h01);
    chk("t7_out", out, 8'h07);
    send_bits(fbits(8'h07, 1'b1), 0, LAST, 1'b1);
    chk("t7_perr", 8'(perr), 8'h01);
    chk("t7_no_fv", 8'(frame_valid), 8'h00);
    chk("t7_out_hold", out, 8'h07);
    chk("t7_locked", 8'(locked), 8'h01);
`endif

    // Randomized traffic: mostly aligned syncs with stalls, drops and misplacements
    gpos = 0;
    for (int n = 0; n < 3000; n++) begin
      e = ($urandom_range(7) != 0);
      d = 1'($urandom);
      if (!e) s = 1'($urandom);
      else if (gpos == 0) s = ($urandom_range(7) != 0);
      else s = ($urandom_range(63) == 0);
      step(e, s, d);
      if (e) gpos = s ? 1 : (gpos + 1) % FLEN;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
